// File: rtl/fp_add_normalize.sv
// Mantissa add/subtract and normalize stage of the single-precision FP adder (truncating).
// Define FP_NORM_LZC_EN to normalize in one cycle with a leading-zero count.
module fp_add_normalize #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_a,
  input  logic                   sign_b,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [MAN_W-1:0]       man_a,
  input  logic [MAN_W-1:0]       man_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   ovf,
  output logic                   uflow
);

  typedef enum logic [1:0] {StIdle, StAdd, StNorm, StDone} state_e;

  localparam logic [EXP_W-1:0] ExpMax = {EXP_W{1'b1}};

  state_e                 state_q, state_d;
  logic                   sign_a_q, sign_a_d, sign_b_q, sign_b_d, sign_q, sign_d;
  logic [EXP_W-1:0]       exp_q, exp_d;
  logic [MAN_W-1:0]       man_a_q, man_a_d, man_b_q, man_b_d, man_q, man_d;
  logic [EXP_W+MAN_W-1:0] result_q, result_d;
  logic                   ovf_q, ovf_d, uflow_q, uflow_d;

  logic                   eff_sub, a_ge_b, sum_sign;
  logic [MAN_W:0]         sum;
  logic [EXP_W-1:0]       exp_inc;
  logic [MAN_W-1:0]       norm_shift;
  logic [EXP_W-1:0]       norm_exp;
  logic                   norm_flush;

  // 25-bit magnitude arithmetic on the captured operands
  always_comb begin
    eff_sub = sign_a_q ^ sign_b_q;
    a_ge_b  = man_a_q >= man_b_q;
    if (!eff_sub) begin
      sum = {1'b0, man_a_q} + {1'b0, man_b_q};
    end else if (a_ge_b) begin
      sum = {1'b0, man_a_q} - {1'b0, man_b_q};
    end else begin
      sum = {1'b0, man_b_q} - {1'b0, man_a_q};
    end
    sum_sign = (eff_sub && !a_ge_b) ? sign_b_q : sign_a_q;
    exp_inc  = exp_q + EXP_W'(1);
  end

`ifdef FP_NORM_LZC_EN
  logic [EXP_W-1:0] lzc;
  logic             lzc_found;

  always_comb begin
    lzc       = '0;
    lzc_found = 1'b0;
    for (int i = MAN_W - 1; i >= 0; i--) begin
      if (!lzc_found) begin
        if (man_q[i]) lzc_found = 1'b1;
        else          lzc = lzc + EXP_W'(1);
      end
    end
  end

  // Shifting far enough to normalize would push the exponent to zero or below
  assign norm_flush = lzc >= exp_q;
  assign norm_shift = man_q << lzc;
  assign norm_exp   = exp_q - lzc;
`else
  assign norm_flush = (exp_q <= EXP_W'(1)) && !man_q[MAN_W-1];
  assign norm_shift = {man_q[MAN_W-2:0], 1'b0};
  assign norm_exp   = exp_q - EXP_W'(1);
`endif

  always_comb begin
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    man_a_d  = man_a_q;
    man_b_d  = man_b_q;
    man_d    = man_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    uflow_d  = uflow_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_a_d = sign_a;
          sign_b_d = sign_b;
          exp_d    = exp_in;
          man_a_d  = man_a;
          man_b_d  = man_b;
          ovf_d    = 1'b0;
          uflow_d  = 1'b0;
          state_d  = StAdd;
        end
      end
      StAdd: begin
        sign_d  = sum_sign;
        state_d = StDone;
        if (exp_q == ExpMax) begin
          result_d = {sign_a_q, ExpMax, man_a_q[MAN_W-2:0]};
        end else if (sum == '0) begin
          result_d = '0;
        end else if (sum[MAN_W]) begin
          if (exp_inc == ExpMax) begin
            result_d = {sum_sign, ExpMax, {(MAN_W-1){1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sum_sign, exp_inc, sum[MAN_W-1:1]};
          end
        end else if (sum[MAN_W-1]) begin
          result_d = {sum_sign, exp_q, sum[MAN_W-2:0]};
        end else begin
          man_d   = sum[MAN_W-1:0];
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (norm_flush) begin
          result_d = {sign_q, {(EXP_W+MAN_W-1){1'b0}}};
          uflow_d  = 1'b1;
          state_d  = StDone;
        end else begin
          man_d = norm_shift;
          exp_d = norm_exp;
          if (norm_shift[MAN_W-1]) begin
            result_d = {sign_q, norm_exp, norm_shift[MAN_W-2:0]};
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_a_q  <= '0;
      man_b_q  <= '0;
      man_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      uflow_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_a_q  <= man_a_d;
      man_b_q  <= man_b_d;
      man_q    <= man_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      uflow_q  <= uflow_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign uflow     = uflow_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed and randomized checks of fp_add_normalize against an arithmetic reference model.
module tb_fp_add_normalize;

  localparam int EW = 8;
  localparam int MW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          sign_a = 1'b0;
  logic          sign_b = 1'b0;
  logic [EW-1:0] exp_in = '0;
  logic [MW-1:0] man_a = '0;
  logic [MW-1:0] man_b = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, ovf, uflow;
  logic [EW+MW-1:0] result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_add_normalize #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .exp_in    (exp_in),
    .man_a     (man_a),
    .man_b     (man_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .uflow     (uflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer add, then normalize by doubling; norm_cyc = cycles spent normalizing
  function automatic void model(input bit sa, input bit sb, input int e, input longint ma,
                                input longint mb, output logic [31:0] r, output bit ov,
                                output bit uf, output int norm_cyc);
    longint s;
    bit     sg;
    int     k;
    r = '0; ov = 1'b0; uf = 1'b0; norm_cyc = 0;
    if (e == 255) begin
      r = {sa, 8'hFF, ma[22:0]};
      return;
    end
    if (sa == sb)      begin s = ma + mb; sg = sa; end
    else if (ma >= mb) begin s = ma - mb; sg = sa; end
    else               begin s = mb - ma; sg = sb; end
    if (s == 0) return;
    if (s >= 64'h1000000) begin
      s = s >> 1;
      if (e + 1 == 255) begin
        r  = {sg, 8'hFF, 23'h0};
        ov = 1'b1;
      end else begin
        r = {sg, 8'(e + 1), s[22:0]};
      end
      return;
    end
    k = 0;
    while (s < 64'h800000) begin
      s = s * 2;
      k++;
    end
    if (k == 0) begin
      r = {sg, 8'(e), s[22:0]};
    end else if (k >= e) begin
      r  = {sg, 31'h0};
      uf = 1'b1;
`ifdef FP_NORM_LZC_EN
      norm_cyc = 1;
`else
      norm_cyc = (e < 1) ? 1 : e;
`endif
    end else begin
      r = {sg, 8'(e - k), s[22:0]};
`ifdef FP_NORM_LZC_EN
      norm_cyc = 1;
`else
      norm_cyc = k;
`endif
    end
  endfunction

  task automatic run_txn(input string tag, input bit sa, input bit sb, input int e,
                         input logic [23:0] ma, input logic [23:0] mb, input int stall);
    logic [31:0] er;
    bit          eo, eu;
    int          nc, lat;
    model(sa, sb, e, 64'(ma), 64'(mb), er, eo, eu, nc);
    @(negedge clk);
    chk({tag, "/in_ready_idle"}, in_ready, 1);
    sign_a = sa; sign_b = sb; exp_in = 8'(e); man_a = ma; man_b = mb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/latency"}, lat, 2 + nc);
    chk({tag, "/out_valid"}, out_valid, 1);
    chk({tag, "/result"}, result, er);
    chk({tag, "/ovf"}, ovf, eo);
    chk({tag, "/uflow"}, uflow, eu);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "/stall_result"}, result, er);
      chk({tag, "/stall_in_ready"}, in_ready, 0);
      chk({tag, "/stall_valid"}, out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "/handoff_valid"}, out_valid, 0);
    chk({tag, "/handoff_ready"}, in_ready, 1);
  endtask

  initial begin
    bit         rsa, rsb;
    int         re;
    logic [23:0] rma, rmb;

    repeat (2) @(negedge clk);
    chk("rst/in_ready", in_ready, 1);
    chk("rst/out_valid", out_valid, 0);
    chk("rst/result", result, 0);
    chk("rst/ovf", ovf, 0);
    chk("rst/uflow", uflow, 0);
    rst_n = 1'b1;

    run_txn("one_plus_one", 0, 0, 127, 24'h800000, 24'h800000, 0);
    run_txn("one5_minus_one", 0, 1, 127, 24'hC00000, 24'h800000, 0);
    run_txn("swap", 0, 1, 127, 24'h800000, 24'hC00000, 0);
    run_txn("cancel", 0, 1, 127, 24'h800000, 24'h800000, 0);
    run_txn("overflow", 0, 0, 254, 24'hFFFFFF, 24'hFFFFFF, 0);
    run_txn("underflow", 0, 1, 2, 24'h800000, 24'h7FFFFF, 0);
    run_txn("passthru", 1, 0, 255, 24'hC12345, 24'h000001, 0);
    run_txn("stall5", 1, 1, 100, 24'hA00000, 24'h123456, 5);
    run_txn("deep_norm", 1, 0, 100, 24'h800000, 24'h7FFFFF, 1);

    // Reset while the transaction is still normalizing
    @(negedge clk);
    sign_a = 1'b0; sign_b = 1'b1; exp_in = 8'd100; man_a = 24'h800000; man_b = 24'h7FFFF0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("midreset/busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset/out_valid", out_valid, 0);
    chk("midreset/in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("midreset/no_emit", out_valid, 0);
    end
    run_txn("after_reset", 0, 0, 127, 24'h800000, 24'h800000, 0);

    for (int i = 0; i < 150; i++) begin
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       re = 255;
        1, 2:    re = $urandom_range(1, 24);
        3:       re = 254;
        default: re = $urandom_range(1, 254);
      endcase
      rma = 24'h800000 | 24'($urandom);
      rmb = (24'h800000 | 24'($urandom)) >> $urandom_range(0, 24);
      case ($urandom_range(0, 7))
        0:       rmb = rma;
        1:       rmb = rma - 24'($urandom_range(1, 64));
        default: ;
      endcase
      run_txn("random", rsa, rsb, re, rma, rmb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
